alu_multicycle: RTL
===================

Name: alu_multicycle

Overview:
- Execute unit that consumes the 3-bit ALU control code produced by the ALU control decoder (add/sub/and/or/mul).
- Executes the operation on two register operands and returns the result.
- add/sub/and/or complete in 1 cycle.
- mul runs as an iterative shift-add over WIDTH cycles; busy_o gives the pipeline a stall source while it runs.

Parameters:
- WIDTH, 32, operand and result width; also the multiply iteration count.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  request; sampled only when busy_o=0.
- flush_i  in  1  synchronous abort of an in-flight multiply.
- ALUCtrl_i  in  3  010 add, 110 sub, 000 and, 001 or, 011 mul; all other codes are illegal.
- data1_i  in  WIDTH  operand A; for sub, result = A-B.
- data2_i  in  WIDTH  operand B.
- data_o  out  WIDTH  registered result; held until the next completion.
- zero_o  out  1  registered (data_o==0), updated together with data_o.
- done_o  out  1  one-cycle completion pulse.
- illegal_o  out  1  pulses with done_o when the control code was illegal.
- busy_o  out  1  high while a multiply is in progress; the pipeline stalls on it.

Behaviour:
- States: IDLE, MUL. busy_o = (state==MUL).
- Reset (asynchronous, any state): state=IDLE; data_o=0, zero_o=1, done_o=0, illegal_o=0, busy_o=0; accumulator, counter and operand registers cleared.
- Pulse outputs: done_o and illegal_o are registered and default to 0 every cycle unless set below.
- IDLE, start_i=1, flush_i=0, code add/sub/and/or:
  - result computed and registered at the same edge; done_o=1 for the following cycle (latency 1).
  - add/sub wrap modulo 2**WIDTH; no carry or overflow output.
- IDLE, start_i=1, code illegal:
  - data_o=0, zero_o=1, done_o=1, illegal_o=1 for one cycle; stay in IDLE.
- IDLE, start_i=1, code mul: at start edge E0:
  - latch mcand=data1_i, mplier=data2_i; acc=0, cnt=0; go to MUL.
- MUL, each edge E1..E32 (one per iteration):
  - if mplier[0], acc += mcand (modulo 2**WIDTH);
  - mcand <<= 1; mplier >>= 1; cnt++.
- MUL, edge EWIDTH (cnt==WIDTH-1):
  - data_o = final acc (low WIDTH bits only); zero_o updated; done_o=1; return to IDLE.
  - done_o is therefore visible in the cycle after E32, for WIDTH=32.
- Back-to-back: start_i is accepted in the same cycle done_o is high; no bubble.
- start_i while busy_o=1: ignored; the operation is not queued.
- flush_i in MUL: return to IDLE at the next edge; no done_o; data_o and zero_o keep their previous values.
- flush_i in IDLE: a coincident start_i is ignored; no done_o.
- Operand inputs may change freely during MUL; only the values latched at E0 are used.
- Reset asserted mid-multiply: the operation is abandoned; all outputs take their reset values immediately.

Decomposition:
- Shared package alu_pkg:
  - localparams ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_MUL=3'b011, ALU_SUB=3'b110 (shared with the ALU control decoder);
  - state encoding IDLE/MUL.
- Sub-module mul_shift_add (WIDTH):
  - holds mcand, mplier, acc and cnt;
  - inputs load, step;
  - outputs last, product.
- alu_multicycle owns the FSM, the single-cycle ops and the output registers.

Test Plan:
- Single-cycle ops: start with add A=5,B=7 -> done_o next cycle, data_o=12, zero_o=0. Then sub 7-7 -> data_o=0, zero_o=1. Then and 0xF0F0&0xFF00 -> 0xF000. Then or 0x0F|0xF0 -> 0xFF.
- Wrap: add A=0xFFFFFFFF, B=1 -> data_o=0, zero_o=1.
- Multiply: mul A=123, B=456:
  - busy_o high from the cycle after E0 through E32;
  - done_o exactly one cycle after E32, data_o=56088;
  - a start_i (add 1+1) pulsed at E10 is ignored.
- Multiply truncation: mul A=0x10000, B=0x10000 -> data_o=0, zero_o=1.
- Illegal code: ALUCtrl_i=3'b111 -> done_o=1, illegal_o=1, data_o=0.
- Abort and back-to-back:
  - flush_i at E15 of mul 3*4 -> IDLE, no done_o, data_o keeps its prior value.
  - Then mul 3*4 followed immediately by add 2+2, start_i held high in the done_o cycle -> 12 then 4 with no idle cycle.
  - rst_i asserted mid-mul -> outputs reset asynchronously.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
//   ALU_* : 3-bit control codes, shared with the ALU control decoder.
//   state_e : FSM encoding for alu_multicycle (IDLE / MUL).
//   is_single_cycle : true for codes that finish in one cycle.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  function automatic logic is_single_cycle(input logic [2:0] code);
    return (code == ALU_AND) || (code == ALU_OR) ||
           (code == ALU_ADD) || (code == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the pipeline and the execute ALU.
//   master : pipeline side (drives request, observes result/status).
//   slave  : ALU side.
//   start_i, flush_i, ALUCtrl_i, data1_i, data2_i : request
//   data_o, zero_o, done_o, illegal_o, busy_o      : result and status
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);

  logic             start_i;
  logic             flush_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             done_o;
  logic             illegal_o;
  logic             busy_o;

  modport master (
    output start_i, flush_i, ALUCtrl_i, data1_i, data2_i,
    input  data_o, zero_o, done_o, illegal_o, busy_o
  );

  modport slave (
    input  start_i, flush_i, ALUCtrl_i, data1_i, data2_i,
    output data_o, zero_o, done_o, illegal_o, busy_o
  );

endinterface

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier datapath, one partial product per step.
//   clk_i, rst_i : clock, async active-high reset
//   load         : capture operands, clear accumulator and counter
//   step         : perform one iteration
//   a, b         : multiplicand / multiplier (sampled on load only)
//   last         : the current step is the final (WIDTH-th) iteration
//   product      : accumulator value after the current step (low WIDTH bits)
// CNT_W must satisfy 2**CNT_W >= WIDTH.
module mul_shift_add #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_sum;

  // Product is exposed as the post-step value so the final iteration's
  // partial product lands in the result register at the same edge.
  assign acc_sum = acc + (mplier[0] ? mcand : '0);
  assign product = acc_sum;
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: add/sub/and/or in one cycle, mul via iterative
// shift-add over WIDTH cycles with busy_o as a pipeline stall source.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : request/response bundle (slave side), see alu_multicycle_if
// Results are registered; done_o/illegal_o are one-cycle pulses and
// data_o/zero_o hold until the next completion.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic               clk_i,
  input logic               rst_i,
  alu_multicycle_if.slave   bus
);

  state_e           state, state_n;
  logic             mul_load, mul_step, mul_last;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_result;
  logic             res_we;
  logic [WIDTH-1:0] res_n;
  logic             done_n, illegal_n;

  mul_shift_add #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (mul_load),
    .step    (mul_step),
    .a       (bus.data1_i),
    .b       (bus.data2_i),
    .last    (mul_last),
    .product (mul_product)
  );

  // NOTE: every signal written in an always_comb gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_result = '0;
    unique case (bus.ALUCtrl_i)
      ALU_ADD: alu_result = bus.data1_i + bus.data2_i;
      ALU_SUB: alu_result = bus.data1_i - bus.data2_i;
      ALU_AND: alu_result = bus.data1_i & bus.data2_i;
      ALU_OR:  alu_result = bus.data1_i | bus.data2_i;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_n   = state;
    mul_load  = 1'b0;
    mul_step  = 1'b0;
    res_we    = 1'b0;
    res_n     = '0;
    done_n    = 1'b0;
    illegal_n = 1'b0;
    unique case (state)
      IDLE: begin
        // A flush coinciding with start cancels the request outright.
        if (bus.start_i && !bus.flush_i) begin
          if (bus.ALUCtrl_i == ALU_MUL) begin
            mul_load = 1'b1;
            state_n  = MUL;
          end else if (is_single_cycle(bus.ALUCtrl_i)) begin
            res_we = 1'b1;
            res_n  = alu_result;
            done_n = 1'b1;
          end else begin
            res_we    = 1'b1;
            res_n     = '0;
            done_n    = 1'b1;
            illegal_n = 1'b1;
          end
        end
      end
      MUL: begin
        // Flush wins over completion: an aborted multiply never reports.
        if (bus.flush_i) begin
          state_n = IDLE;
        end else begin
          mul_step = 1'b1;
          if (mul_last) begin
            res_we  = 1'b1;
            res_n   = mul_product;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      bus.data_o    <= '0;
      bus.zero_o    <= 1'b1;
      bus.done_o    <= 1'b0;
      bus.illegal_o <= 1'b0;
    end else begin
      state         <= state_n;
      bus.done_o    <= done_n;
      bus.illegal_o <= illegal_n;
      if (res_we) begin
        bus.data_o <= res_n;
        bus.zero_o <= (res_n == '0);
      end
    end
  end

  assign bus.busy_o = (state == MUL);

endmodule
